// File: rtl/uart_transmitter.sv
// 8N1 UART transmit engine: a small byte FIFO fed over valid/ready, drained by a
// start/data/stop serializer that holds every bit for CLOCK_FREQ/BAUD_RATE cycles.
module uart_transmitter #(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [7:0]                    data_in,
   input  logic                          data_in_valid,
   output logic                          data_in_ready,
   output logic                          serial_out,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
   localparam int CW   = $clog2(SYMBOL_EDGE_TIME);
   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int CNTW = PW + 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t         state, state_next;
   logic [CW-1:0]  baud_cnt, baud_cnt_next;
   logic [2:0]     bit_idx, bit_idx_next;
   logic [7:0]     shift_reg, shift_next;
   logic           serial_next;
   logic           baud_wrap;

   logic [7:0]     mem [FIFO_DEPTH];
   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic           push, pop;

   // Readiness depends only on the registered count, never on data_in_valid.
   assign data_in_ready = !reset && (fifo_count != CNTW'(FIFO_DEPTH));
   assign push          = data_in_valid && data_in_ready;
   assign tx_busy       = (state != IDLE) || (fifo_count != '0);
   assign baud_wrap     = (baud_cnt == CW'(SYMBOL_EDGE_TIME - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      fifo_count <= fifo_count + 1'b1;
         else if (pop && !push) fifo_count <= fifo_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         shift_reg  <= '0;
         serial_out <= 1'b1;
      end else begin
         state      <= state_next;
         baud_cnt   <= baud_cnt_next;
         bit_idx    <= bit_idx_next;
         shift_reg  <= shift_next;
         serial_out <= serial_next;
      end
   end

   // The next line level is computed here and registered, so bit edges only
   // happen on a baud-counter wrap (or on a load from IDLE).
   always_comb begin
      state_next    = state;
      baud_cnt_next = baud_wrap ? '0 : baud_cnt + 1'b1;
      bit_idx_next  = bit_idx;
      shift_next    = shift_reg;
      serial_next   = serial_out;
      pop           = 1'b0;
      case (state)
         IDLE: begin
            baud_cnt_next = '0;
            serial_next   = 1'b1;
            if (fifo_count != '0) begin
               pop          = 1'b1;
               shift_next   = mem[rd_ptr];
               serial_next  = 1'b0;
               bit_idx_next = '0;
               state_next   = START;
            end
         end
         START: begin
            if (baud_wrap) begin
               serial_next = shift_reg[0];
               shift_next  = shift_reg >> 1;
               state_next  = DATA;
            end
         end
         DATA: begin
            if (baud_wrap) begin
               if (bit_idx == 3'd7) begin
                  serial_next = 1'b1;
                  state_next  = STOP;
               end else begin
                  serial_next  = shift_reg[0];
                  shift_next   = shift_reg >> 1;
                  bit_idx_next = bit_idx + 1'b1;
               end
            end
         end
         STOP: begin
            // Chain the next frame straight out of the stop bit when data waits.
            if (baud_wrap) begin
               if (fifo_count != '0) begin
                  pop          = 1'b1;
                  shift_next   = mem[rd_ptr];
                  serial_next  = 1'b0;
                  bit_idx_next = '0;
                  state_next   = START;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: a frame-level line model checked every cycle, a
// loopback receiver per instance, and hand-computed frame/timing expectations.
module tb_uart_transmitter;

   localparam int SET   = 434;
   localparam int SSET  = 3;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] data_in, s_data;
   logic       data_in_valid, s_valid;
   logic       data_in_ready, serial_out, tx_busy;
   logic [2:0] fifo_count;
   logic       s_ready, s_serial, s_busy;
   logic [2:0] s_count;

   int total = 0;
   int bad   = 0;
   int max_cnt = 0;

   logic [7:0] q_m[$];
   logic [7:0] m_cur;
   bit         m_idle = 1'b1;
   bit         m_on   = 1'b0;
   int         m_phase = 0;

   logic [7:0] rx_q0[$];
   logic [7:0] rx_q1[$];
   bit         rx_act[2];
   int         rx_cnt[2];
   logic [7:0] rx_sh[2];

   uart_transmitter dut (
      .clk(clk), .reset(reset), .data_in(data_in), .data_in_valid(data_in_valid),
      .data_in_ready(data_in_ready), .serial_out(serial_out), .tx_busy(tx_busy),
      .fifo_count(fifo_count)
   );

   uart_transmitter #(.CLOCK_FREQ(1000), .BAUD_RATE(300), .FIFO_DEPTH(4)) dut_small (
      .clk(clk), .reset(reset), .data_in(s_data), .data_in_valid(s_valid),
      .data_in_ready(s_ready), .serial_out(s_serial), .tx_busy(s_busy),
      .fifo_count(s_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 30) $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic frameBit(input logic [7:0] d, input int k);
      if (k == 0) return 1'b0;
      if (k >= 9) return 1'b1;
      return d[k-1];
   endfunction

   function automatic logic [7:0] rx0(input int i);
      if (i < rx_q0.size()) return rx_q0[i];
      return 8'hxx;
   endfunction

   // Line model: a byte queue plus a position inside the current 10-bit frame.
   always @(posedge clk) begin : line_model
      bit acc;
      if (reset) begin
         q_m.delete();
         m_idle  = 1'b1;
         m_phase = 0;
         m_on    = 1'b1;
      end else if (m_on) begin
         acc = data_in_valid && (q_m.size() < DEPTH);
         if (!m_idle) begin
            m_phase++;
            if (m_phase == 10 * SET) m_idle = 1'b1;
         end
         if (m_idle && q_m.size() != 0) begin
            m_cur   = q_m.pop_front();
            m_idle  = 1'b0;
            m_phase = 0;
         end
         if (acc) q_m.push_back(data_in);
      end
   end

   always @(negedge clk) begin
      if (m_on) begin
         checkOutput("serial_out", serial_out, m_idle ? 1'b1 : frameBit(m_cur, m_phase / SET));
         checkOutput("fifo_count", fifo_count, q_m.size());
         checkOutput("tx_busy", tx_busy, (!m_idle || q_m.size() != 0));
         checkOutput("data_in_ready", data_in_ready, (!reset && q_m.size() < DEPTH));
         if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      end
   end

   // Loopback receivers sample each bit at its centre; reset abandons a frame.
   always @(negedge clk) begin
      for (int ch = 0; ch < 2; ch++) begin
         logic line;
         int   set;
         int   k;
         line = (ch == 0) ? serial_out : s_serial;
         set  = (ch == 0) ? SET : SSET;
         if (reset) begin
            rx_act[ch] = 1'b0;
         end else if (!rx_act[ch]) begin
            if (line === 1'b0) begin
               rx_act[ch] = 1'b1;
               rx_cnt[ch] = 0;
            end
         end else begin
            rx_cnt[ch]++;
            if (rx_cnt[ch] % set == set / 2) begin
               k = rx_cnt[ch] / set;
               if (k >= 1 && k <= 8) begin
                  rx_sh[ch][k-1] = line;
               end else if (k == 9) begin
                  checkOutput("rx_stop_bit", line, 1'b1);
                  if (ch == 0) rx_q0.push_back(rx_sh[ch]);
                  else         rx_q1.push_back(rx_sh[ch]);
                  rx_act[ch] = 1'b0;
               end
            end
         end
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [31:0] w, input int n);
      for (int i = 0; i < n; i++) begin
         data_in       = w[8*i +: 8];
         data_in_valid = 1'b1;
         @(posedge clk);
         #1;
      end
      data_in_valid = 1'b0;
   endtask

   task automatic measureFrame(output int len, output logic [9:0] bits);
      int g = 0;
      int n = 0;
      bits = '0;
      while (serial_out !== 1'b0 && g < 100) begin
         @(negedge clk);
         g++;
      end
      checkOutput("frame_start_seen", (g < 100), 1'b1);
      while (tx_busy !== 1'b0 && n < 20 * 10 * SET) begin
         if (n % SET == SET / 2 && n / SET < 10) bits[n / SET] = serial_out;
         @(negedge clk);
         n++;
      end
      len = n;
   endtask

   task automatic waitIdle(input int limit);
      int g = 0;
      while (tx_busy !== 1'b0 && g < limit) begin
         @(negedge clk);
         g++;
      end
      checkOutput("idle_reached", (g < limit), 1'b1);
   endtask

   initial begin
      #(100000 * 10);
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int         len, g, i, guard, lows;
      logic [9:0] bits;
      logic [39:0] hold_bytes;
      logic [7:0] exp3 [6];
      logic [9:0] exp5;
      logic       rdy;

      reset = 1'b1; data_in_valid = 1'b0; data_in = '0; s_valid = 1'b0; s_data = '0;
      @(negedge clk);
      checkOutput("reset_ready", data_in_ready, 1'b0);
      checkOutput("reset_serial", serial_out, 1'b1);
      checkOutput("reset_count", fifo_count, 3'd0);
      checkOutput("reset_busy", tx_busy, 1'b0);
      waitCycles(3);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("ready_after_reset", data_in_ready, 1'b1);

      $display("[TB] single byte 0x55");
      rx_q0.delete();
      fork
         applyStimulus(32'h55, 1);
         measureFrame(len, bits);
      join
      checkOutput("t1_frame_bits", bits, 10'b1010101010);
      checkOutput("t1_busy_cycles", len, 4340);
      checkOutput("t1_rx_count", rx_q0.size(), 1);
      checkOutput("t1_rx_byte", rx0(0), 8'h55);

      $display("[TB] back-to-back four bytes");
      waitCycles(5);
      rx_q0.delete();
      max_cnt = 0;
      fork
         applyStimulus(32'h00FF3CA5, 4);
         measureFrame(len, bits);
      join
      checkOutput("t2_first_frame_bits", bits, 10'b1101001010);
      checkOutput("t2_contiguous_cycles", len, 17360);
      checkOutput("t2_max_count", max_cnt, 3);
      checkOutput("t2_rx_count", rx_q0.size(), 4);
      checkOutput("t2_rx0", rx0(0), 8'hA5);
      checkOutput("t2_rx1", rx0(1), 8'h3C);
      checkOutput("t2_rx2", rx0(2), 8'hFF);
      checkOutput("t2_rx3", rx0(3), 8'h00);

      $display("[TB] valid held high against a full FIFO");
      waitCycles(5);
      rx_q0.delete();
      max_cnt = 0;
      exp3 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      applyStimulus(32'h11, 1);
      waitCycles(100);
      hold_bytes = 40'h66_55_44_33_22;
      i = 0; guard = 0;
      data_in = hold_bytes[7:0];
      data_in_valid = 1'b1;
      while (i < 5 && guard < 30000) begin
         @(negedge clk);
         rdy = data_in_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            i++;
            if (i < 5) data_in = hold_bytes[8*i +: 8];
         end
         guard++;
      end
      data_in_valid = 1'b0;
      checkOutput("t3_all_accepted", i, 5);
      waitIdle(40000);
      checkOutput("t3_max_count", max_cnt, 4);
      checkOutput("t3_rx_count", rx_q0.size(), 6);
      for (int j = 0; j < 6; j++) checkOutput("t3_rx_byte", rx0(j), exp3[j]);

      $display("[TB] reset during data bit 3");
      waitCycles(5);
      rx_q0.delete();
      applyStimulus(32'h0F, 1);
      waitCycles(1 + 4 * SET + 200);
      checkOutput("t4_in_frame", tx_busy, 1'b1);
      reset = 1'b1;
      waitCycles(1);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("t4_serial", serial_out, 1'b1);
      checkOutput("t4_count", fifo_count, 3'd0);
      checkOutput("t4_busy", tx_busy, 1'b0);
      lows = 0;
      repeat (5000) begin
         @(negedge clk);
         if (serial_out !== 1'b1) lows++;
      end
      checkOutput("t4_line_stays_idle", lows, 0);
      checkOutput("t4_no_rx", rx_q0.size(), 0);

      $display("[TB] edge time 3, byte 0x81");
      waitCycles(1);
      exp5 = 10'b1100000010;
      s_data = 8'h81;
      s_valid = 1'b1;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      g = 0;
      while (s_serial !== 1'b0 && g < 10) begin
         @(negedge clk);
         g++;
      end
      checkOutput("t5_latency", g, 2);
      for (int k = 0; k < 30; k++) begin
         checkOutput("t5_line", s_serial, exp5[k / SSET]);
         @(negedge clk);
      end
      checkOutput("t5_busy_end", s_busy, 1'b0);
      checkOutput("t5_serial_end", s_serial, 1'b1);
      checkOutput("t5_count_end", s_count, 3'd0);
      waitCycles(5);
      checkOutput("t5_rx_count", rx_q1.size(), 1);
      checkOutput("t5_rx_byte", (rx_q1.size() > 0) ? rx_q1[0] : 8'hxx, 8'h81);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
